// File: rtl/uart_msg_streamer.sv
// UART transmitter that sends a latched multi-byte message (optionally repeated) on tx after a start pulse.
// Each line bit lasts DIV = clk_freq/baud_rate cycles; start is ignored while busy.
module uart_msg_streamer #(
  parameter int clk_freq       = 1000000,
  parameter int baud_rate      = 9600,
  parameter int msg_size_byte  = 6,
  parameter int data_bits      = 8,
  parameter int parity_mode    = 0,
  parameter int stop_bits      = 1,
  parameter int lsb_byte_first = 1,
  parameter int gap_bits       = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [8*msg_size_byte-1:0]         msg,
  input  logic [7:0]                         repeat_count,
  output logic                               tx,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(msg_size_byte):0]     byte_index
);

  localparam int DIV     = clk_freq / baud_rate;
  localparam int BW      = $clog2(DIV);
  localparam int BIW     = $clog2(msg_size_byte) + 1;
  localparam int SUB_MAX = (data_bits > stop_bits)
                         ? ((data_bits > gap_bits) ? data_bits : gap_bits)
                         : ((stop_bits > gap_bits) ? stop_bits : gap_bits);
  localparam int SW      = $clog2(SUB_MAX + 1);

  localparam logic [BW-1:0]  BIT_LAST  = BW'(DIV - 1);
  localparam logic [SW-1:0]  DATA_LAST = SW'(data_bits - 1);
  localparam logic [SW-1:0]  STOP_LAST = SW'(stop_bits - 1);
  localparam logic [SW-1:0]  GAP_LAST  = SW'((gap_bits > 0) ? gap_bits - 1 : 0);
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(msg_size_byte - 1);
  localparam logic [7:0]     DMASK     = 8'((1 << data_bits) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t                     state;
  logic [BW-1:0]              bit_cnt;
  logic [SW-1:0]              sub_cnt;
  logic [7:0]                 pass;
  logic [7:0]                 rep_q;
  logic [8*msg_size_byte-1:0] msg_q;
  logic [7:0]                 shreg;
  logic [7:0]                 cur_byte;
  logic                       par_bit;
  int                         sel;

  // byte_index is in transmission order; map it onto the latched message
  always_comb begin
    sel      = (lsb_byte_first != 0) ? int'(byte_index)
                                     : msg_size_byte - 1 - int'(byte_index);
    cur_byte = msg_q[8*sel +: 8];
    par_bit  = (^(cur_byte & DMASK)) ^ (parity_mode == 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_index <= '0;
      bit_cnt    <= '0;
      sub_cnt    <= '0;
      pass       <= '0;
      rep_q      <= '0;
      msg_q      <= '0;
      shreg      <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        tx         <= 1'b1;
        busy       <= 1'b0;
        byte_index <= '0;
        if (start) begin
          msg_q   <= msg;
          rep_q   <= repeat_count;
          pass    <= '0;
          bit_cnt <= '0;
          state   <= S_START;
          tx      <= 1'b0;
          busy    <= 1'b1;
        end
      end else if (bit_cnt != BIT_LAST) begin
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            sub_cnt <= '0;
            tx      <= cur_byte[0];
            shreg   <= cur_byte >> 1;
          end
          S_DATA: begin
            if (sub_cnt != DATA_LAST) begin
              sub_cnt <= sub_cnt + SW'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end else if (parity_mode != 0) begin
              state <= S_PARITY;
              tx    <= par_bit;
            end else begin
              state   <= S_STOP;
              sub_cnt <= '0;
              tx      <= 1'b1;
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            sub_cnt <= '0;
            tx      <= 1'b1;
          end
          S_STOP: begin
            if (sub_cnt != STOP_LAST) begin
              sub_cnt <= sub_cnt + SW'(1);
            end else if (byte_index != BYTE_LAST || pass != rep_q) begin
              // next byte of this pass, or first byte of the next pass
              if (byte_index != BYTE_LAST) begin
                byte_index <= byte_index + BIW'(1);
              end else begin
                byte_index <= '0;
                pass       <= pass + 8'd1;
              end
              if (gap_bits > 0) begin
                state   <= S_GAP;
                sub_cnt <= '0;
                tx      <= 1'b1;
              end else begin
                state <= S_START;
                tx    <= 1'b0;
              end
            end else begin
              state      <= S_IDLE;
              tx         <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
              byte_index <= '0;
            end
          end
          S_GAP: begin
            if (sub_cnt != GAP_LAST) begin
              sub_cnt <= sub_cnt + SW'(1);
            end else begin
              state <= S_START;
              tx    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
